// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module  : pipe_pkg
//  Brief   : Shared defaults, hazard-control bundle and pointer-wrap helper
//            for the elastic pipeline stage registers.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int PIPE_DEPTH_DEFAULT = 2;
    localparam int PIPE_WIDTH_DEFAULT = 32;

    typedef struct packed {
        logic stall;
        logic flush;
    } pipe_ctrl_t;

    // Explicit compare so non-power-of-2 depths wrap at DEPTH-1.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ring_ptr.sv
// ============================================================================
//  Module  : ring_ptr
//  Brief   : Single wrapping ring-buffer pointer with increment enable and
//            synchronous clear (active-low synchronous reset).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ring_ptr
    import pipe_pkg::*;
#(
    parameter int DEPTH = PIPE_DEPTH_DEFAULT,
    parameter int PTR_W = 1
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = PTR_W'(ptr_inc(32'(ptr_q), DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/elastic_pipe_reg.sv
// ============================================================================
//  Module  : elastic_pipe_reg
//  Brief   : DEPTH-entry elastic pipeline register with valid/ready on both
//            sides plus stage-wide stall and flush. Optional zero-latency
//            bypass when empty is enabled by macro PIPE_BYPASS_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEFAULT,
    parameter int DEPTH = PIPE_DEPTH_DEFAULT
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    pipe_ctrl_t       ctrl;
    logic             active;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign ctrl   = '{stall: stall, flush: flush};
    assign active = nRST & ~ctrl.flush & ~ctrl.stall;
    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));

    // Full buffer refuses input even while popping: no out_ready -> in_ready path.
    assign in_ready = active & ~full;

`ifdef PIPE_BYPASS_EN
    logic byp_take;

    assign out_valid = empty ? (active & in_valid) : active;
    assign out_data  = (active & empty) ? in_data : mem_q[rd_ptr];
    assign byp_take  = active & empty & in_valid & out_ready;
    assign push      = in_valid & in_ready & ~byp_take;
    assign pop       = active & ~empty & out_ready;
`else
    assign out_valid = active & ~empty;
    assign out_data  = mem_q[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
`endif

    ring_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk_i  (CLK),
        .nrst_i (nRST),
        .clr_i  (flush),
        .inc_i  (push),
        .ptr_o  (wr_ptr)
    );

    ring_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk_i  (CLK),
        .nrst_i (nRST),
        .clr_i  (flush),
        .inc_i  (pop),
        .ptr_o  (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flush leaves storage untouched; only the pointers and count are cleared.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr] <= in_data;
        end
    end

    assign count = count_q;

`ifndef SYNTHESIS
    a_no_overflow:  assert property (@(posedge CLK) disable iff (!nRST) push |-> !full);
    a_no_underflow: assert property (@(posedge CLK) disable iff (!nRST) pop |-> !empty);
`endif

endmodule

`default_nettype wire

// File: tb/tb_elastic_pipe_reg.sv
// ============================================================================
//  Module  : tb_elastic_pipe_reg
//  Brief   : Scoreboard bench for elastic_pipe_reg (DEPTH=3) with directed
//            sequences followed by randomized traffic.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_elastic_pipe_reg;

    localparam int W  = 16;
    localparam int D  = 3;
    localparam int CW = $clog2(D + 1);

    logic          CLK = 1'b0;
    logic          nRST;
    logic          stall;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;

    int           total = 0;
    int           bad   = 0;
    bit           known = 1'b0;
    logic [W-1:0] exp_q[$];

    elastic_pipe_reg #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic f, input logic v,
                        input logic [W-1:0] d, input logic r);
        stall     = s;
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge CLK);
        #1;
    endtask

    // Reference model: a FIFO of accepted words, updated on each edge from the
    // inputs held during the preceding cycle.
    always @(posedge CLK) begin
        int  sz;
        bit  take_out;
        bit  take_in;
        bit  byp;
        sz = exp_q.size();
        if (!nRST) begin
            exp_q.delete();
            known = 1'b1;
        end else if (flush) begin
            exp_q.delete();
        end else if (!stall && known) begin
            byp = 1'b0;
`ifdef PIPE_BYPASS_EN
            byp = (sz == 0) && in_valid && out_ready;
`endif
            take_out = (sz != 0) && out_ready;
            take_in  = in_valid && (sz < D) && !byp;
            if (take_out) void'(exp_q.pop_front());
            if (take_in)  exp_q.push_back(in_data);
        end
    end

    // Monitor: compares DUT handshakes, occupancy and head word to the model.
    always @(negedge CLK) begin
        bit           act_en;
        bit           e_ir;
        bit           e_ov;
        logic [W-1:0] e_od;
        int           sz;
        if (known) begin
            sz     = exp_q.size();
            act_en = nRST && !flush && !stall;
            e_ir   = act_en && (sz < D);
            e_ov   = act_en && (sz != 0);
            e_od   = (sz != 0) ? exp_q[0] : '0;
`ifdef PIPE_BYPASS_EN
            if (act_en && sz == 0) begin
                e_ov = in_valid;
                e_od = in_data;
            end
`endif
            chk("in_ready",  32'(in_ready),  32'(e_ir));
            chk("out_valid", 32'(out_valid), 32'(e_ov));
            chk("count",     32'(count),     32'(sz));
            if (e_ov && out_valid === 1'b1) begin
                chk("out_data", 32'(out_data), 32'(e_od));
            end
        end
    end

    initial begin
        nRST = 1'b0;
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        nRST = 1'b1;
        #1;
        chk("rel_in_ready",  32'(in_ready),  32'd1);

        // Fill then drain
        for (int i = 0; i < 3; i++) step(0, 0, 1, W'(16'hA + i), 0);
        step(0, 0, 0, '0, 0);
        chk("full_count",    32'(count),     32'd3);
        chk("full_in_ready", 32'(in_ready),  32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1);
        chk("drained_count", 32'(count),     32'd0);

        // Streaming
        for (int i = 0; i < 10; i++) step(0, 0, 1, W'(16'h100 + i), 1);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);

        // Interleaved push/pop so both pointers wrap twice
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, W'(16'h200 + i), 0);
            step(0, 0, 0, '0, 1);
        end

        // Flush dominates stall
        step(0, 0, 1, 16'h31, 0);
        step(0, 0, 1, 16'h32, 0);
        chk("pre_flush_count", 32'(count), 32'd2);
        step(1, 1, 1, 16'h33, 1);
        stall = 0; flush = 0; in_valid = 0; out_ready = 0;
        #1;
        chk("flush_count",     32'(count),     32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        step(0, 0, 1, 16'h5, 0);
        in_valid = 0;
        #1;
        chk("post_flush_valid", 32'(out_valid), 32'd1);
        chk("post_flush_data",  32'(out_data),  32'h5);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 0);

        // Empty buffer, word offered with downstream ready
        stall = 0; flush = 0; in_valid = 1; in_data = 16'h77; out_ready = 1;
        #1;
`ifdef PIPE_BYPASS_EN
        chk("byp_valid", 32'(out_valid), 32'd1);
        chk("byp_data",  32'(out_data),  32'h77);
        step(0, 0, 1, 16'h77, 1);
        chk("byp_count", 32'(count), 32'd0);
`else
        chk("nobyp_valid", 32'(out_valid), 32'd0);
        step(0, 0, 1, 16'h77, 1);
        chk("nobyp_count", 32'(count), 32'd1);
`endif
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            nRST = ($urandom % 64) != 0;
            step(($urandom % 8) == 0, ($urandom % 32) == 0, ($urandom % 4) != 0,
                 W'($urandom), (i < 750) ? (($urandom % 3) == 0) : (($urandom % 3) != 0));
        end
        nRST = 1'b1;
        step(0, 0, 0, '0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
